// File: rtl/psum_ofifo.sv
// Output FIFO for a systolic array's south edge: one independent queue per column
// absorbs skewed psum arrival, and whole rows are popped once every column has data.

module psum_ofifo_col #(
    parameter int psum_bw = 16,
    parameter int depth   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               pop,
    input  logic [psum_bw-1:0] din,
    output logic [psum_bw-1:0] head,
    output logic               full,
    output logic               nonempty,
    output logic               drop
);
    localparam int AW = $clog2(depth);

    logic [AW-1:0]      wp_q, wp_d;
    logic [AW-1:0]      rp_q, rp_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic [psum_bw-1:0] mem_q [depth];
    logic [psum_bw-1:0] mem_d [depth];
    logic               wr_acc;

    // pop is only raised by the parent when every column is non-empty,
    // so this queue never has to guard against underflow itself.
    always_comb begin
        full     = (cnt_q == (AW+1)'(depth));
        nonempty = (cnt_q != '0);
        wr_acc   = wr && (!full || pop);
        drop     = wr && full && !pop;
        wp_d     = wp_q;
        rp_d     = rp_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        if (wr_acc) begin
            mem_d[wp_q] = din;
            wp_d        = wp_q + 1'b1;
        end
        if (pop) begin
            rp_d = rp_q + 1'b1;
        end
        case ({wr_acc, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    assign head = mem_q[rp_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is left unreset; pointers and counts alone define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

module psum_ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   out_valid,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   overflow
);
    logic [col-1:0][psum_bw-1:0] in_v;
    logic [col-1:0][psum_bw-1:0] head_v;
    logic [col-1:0][psum_bw-1:0] out_q, out_d;
    logic [col-1:0]              full_v;
    logic [col-1:0]              nonempty_v;
    logic [col-1:0]              drop_v;
    logic                        pop;
    logic                        out_valid_q, out_valid_d;
    logic                        overflow_q, overflow_d;

    assign in_v = in;

    for (genvar gi = 0; gi < col; gi++) begin : g_col
        psum_ofifo_col #(
            .psum_bw(psum_bw),
            .depth  (depth)
        ) u_col (
            .clk     (clk),
            .reset   (reset),
            .wr      (wr[gi]),
            .pop     (pop),
            .din     (in_v[gi]),
            .head    (head_v[gi]),
            .full    (full_v[gi]),
            .nonempty(nonempty_v[gi]),
            .drop    (drop_v[gi])
        );
    end

    // Status flags come only from registered counts, keeping them free of
    // combinational paths from the array-side strobes.
    always_comb begin
        o_valid     = &nonempty_v;
        o_full      = |full_v;
        o_ready     = !o_full;
        pop         = rd && o_valid;
        out_d       = pop ? head_v : out_q;
        out_valid_d = pop;
        overflow_d  = overflow_q || (|drop_v);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_psum_ofifo.sv
// Bench for psum_ofifo: directed table, corner sequences and random traffic,
// all checked against a queue-based row model.

module tb_psum_ofifo;
    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 8;

    typedef logic [COL-1:0][BW-1:0] row_t;

    typedef struct {
        logic [COL-1:0] wr;
        row_t           d;
        logic           rd;
        logic           e_ov;
        logic           e_outv;
        logic           e_full;
        logic           e_ovf;
        row_t           e_out;
    } vec_t;

    logic           clk, reset, rd;
    logic [COL-1:0] wr;
    row_t           din, dout;
    logic           out_valid, o_valid, o_full, o_ready, overflow;

    psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (din),
        .wr       (wr),
        .rd       (rd),
        .out      (dout),
        .out_valid(out_valid),
        .o_valid  (o_valid),
        .o_full   (o_full),
        .o_ready  (o_ready),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec, n_err;

    // Reference model: one queue per column, rows leave when all are non-empty.
    logic [BW-1:0] q [COL][$];
    row_t          out_m;
    logic          outv_m, ovf_m;

    function automatic row_t mk_row(input logic [BW-1:0] base);
        row_t r;
        for (int i = 0; i < COL; i++) r[i] = base + BW'(i);
        return r;
    endfunction

    function automatic logic m_ovalid();
        logic v = 1'b1;
        for (int i = 0; i < COL; i++) if (q[i].size() == 0) v = 1'b0;
        return v;
    endfunction

    function automatic logic m_full();
        logic f = 1'b0;
        for (int i = 0; i < COL; i++) if (q[i].size() == DEPTH) f = 1'b1;
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < COL; i++) q[i].delete();
        out_m  = '0;
        outv_m = 1'b0;
        ovf_m  = 1'b0;
    endtask

    task automatic model_step(input logic [COL-1:0] w, input row_t d, input logic r);
        logic p;
        p      = r && m_ovalid();
        outv_m = p;
        if (p) for (int i = 0; i < COL; i++) out_m[i] = q[i].pop_front();
        for (int i = 0; i < COL; i++) begin
            if (w[i]) begin
                if (q[i].size() < DEPTH) q[i].push_back(d[i]);
                else ovf_m = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        n_vec++;
        if (dout !== out_m || out_valid !== outv_m || o_valid !== m_ovalid() ||
            o_full !== m_full() || o_ready !== !m_full() || overflow !== ovf_m) begin
            n_err++;
            $display("FAIL %s: got out=%h ov=%b v=%b f=%b r=%b of=%b, want out=%h ov=%b v=%b f=%b r=%b of=%b",
                     tag, dout, out_valid, o_valid, o_full, o_ready, overflow,
                     out_m, outv_m, m_ovalid(), m_full(), !m_full(), ovf_m);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", tag, got, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic [COL-1:0] w, input row_t d, input logic r, input string tag);
        wr  = w;
        din = d;
        rd  = r;
        @(posedge clk);
        model_step(w, d, r);
        #1;
        check_model(tag);
        wr = '0;
        rd = 1'b0;
    endtask

    // Reset asserted between edges: outputs must clear before any clock edge.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_model({tag, "_imm"});
        chk1({tag, "_ready"}, o_ready, 1'b1);
        @(posedge clk);
        #1;
        check_model({tag, "_held"});
        #2 reset = 1'b0;
    endtask

    function automatic vec_t mkv(input logic [COL-1:0] w, input row_t d, input logic r,
                                 input logic ov, input logic outv, input logic f,
                                 input logic of, input row_t eo);
        vec_t v;
        v.wr = w; v.d = d; v.rd = r;
        v.e_ov = ov; v.e_outv = outv; v.e_full = f; v.e_ovf = of; v.e_out = eo;
        return v;
    endfunction

    vec_t tbl [14];

    initial begin
        row_t d, r1, r2;
        int   written, pulses;

        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        wr    = '0;
        rd    = 1'b0;
        din   = '0;
        model_reset();

        // Skewed fill, empty read, partial-row read.
        r1 = mk_row(16'h0100);
        r2 = mk_row(16'h0200);
        for (int i = 0; i < COL; i++) begin
            d    = {COL{16'hDEAD}};
            d[i] = 16'h0100 + BW'(i);
            tbl[i] = mkv(COL'(1) << i, d, 1'b0, (i == COL-1), 1'b0, 1'b0, 1'b0, '0);
        end
        tbl[8]  = mkv('0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, r1);
        tbl[9]  = mkv('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, r1);
        tbl[10] = mkv(8'h7F, r2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r1);
        tbl[11] = mkv('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, r1);
        tbl[12] = mkv(8'h80, r2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, r1);
        tbl[13] = mkv('0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, r2);

        #12;
        check_model("reset_state");
        chk1("reset_ready", o_ready, 1'b1);
        #1 reset = 1'b0;

        for (int k = 0; k < 14; k++) begin
            cycle(tbl[k].wr, tbl[k].d, tbl[k].rd, $sformatf("tbl%0d_model", k));
            n_vec++;
            if (o_valid !== tbl[k].e_ov || out_valid !== tbl[k].e_outv ||
                o_full !== tbl[k].e_full || overflow !== tbl[k].e_ovf || dout !== tbl[k].e_out) begin
                n_err++;
                $display("FAIL tbl%0d: got v=%b ov=%b f=%b of=%b out=%h, want v=%b ov=%b f=%b of=%b out=%h",
                         k, o_valid, out_valid, o_full, overflow, dout,
                         tbl[k].e_ov, tbl[k].e_outv, tbl[k].e_full, tbl[k].e_ovf, tbl[k].e_out);
            end
        end

        // Fill to full, drop a write to column 3, then drain in order.
        for (int r = 0; r < DEPTH; r++) cycle('1, mk_row(BW'(16'h0300 + r*16)), 1'b0, "fill");
        chk1("full_flag", o_full, 1'b1);
        chk1("full_ready", o_ready, 1'b0);
        cycle(8'h08, mk_row(16'hBAD0), 1'b0, "ovf_write");
        chk1("ovf_set", overflow, 1'b1);
        for (int r = 0; r < DEPTH; r++) begin
            cycle('0, '0, 1'b1, "drain");
            chkw($sformatf("col3_pop%0d", r), dout[3], BW'(16'h0303 + r*16));
        end
        chk1("ovf_sticky", overflow, 1'b1);
        async_reset("rst_a");

        // Write into full queues on the same edge as a pop.
        for (int r = 0; r < DEPTH; r++) cycle('1, mk_row(BW'(16'h0400 + r*16)), 1'b0, "fill2");
        cycle('1, mk_row(16'h0480), 1'b1, "full_pop_wr");
        chk1("fpw_no_ovf", overflow, 1'b0);
        chk1("fpw_full", o_full, 1'b1);
        for (int r = 0; r < DEPTH; r++) cycle('0, '0, 1'b1, "drain2");
        chkw("ninth_row_col0", dout[0], 16'h0480);
        chkw("ninth_row_col7", dout[7], 16'h0487);

        // Streaming with wrap-around, occupancy kept at 4 or below.
        written = 0;
        pulses  = 0;
        for (int c = 0; c < 80 && (written < 20 || q[0].size() != 0); c++) begin
            logic wv, rv;
            wv = (written < 20) && (q[0].size() < 4);
            rv = (q[0].size() >= 2) || (written == 20);
            cycle({COL{wv}}, mk_row(BW'(16'h0500 + written*16)), rv, "stream");
            if (wv) written++;
            if (out_valid) pulses++;
        end
        chkw("stream_pulses", BW'(pulses), 16'd20);
        chk1("stream_no_ovf", overflow, 1'b0);

        // Async reset with three rows queued, right after a pop pulse.
        for (int r = 0; r < 4; r++) cycle('1, mk_row(BW'(16'h0600 + r*16)), 1'b0, "pre_rst");
        cycle('0, '0, 1'b1, "pre_rst_pop");
        async_reset("rst_b");
        cycle('0, '0, 1'b1, "post_rst_rd");
        chk1("post_rst_no_outv", out_valid, 1'b0);
        cycle('1, mk_row(16'h0700), 1'b0, "post_rst_wr");
        cycle('0, '0, 1'b1, "post_rst_pop");
        chkw("post_rst_data", dout[5], 16'h0705);

        // Random traffic: write-heavy first, then read-heavy.
        for (int c = 0; c < 400; c++) begin
            row_t rd_row;
            logic rr;
            for (int i = 0; i < COL; i++) rd_row[i] = BW'($urandom);
            rr = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle(COL'($urandom), rd_row, rr, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
